alu_acc_ctrl: RTL and testbench

- Sequential control stage that wraps the N-bit combinational ALU (add, sub, and, or, xor; opcodes 0000-0100).
- Accepts operation commands over a valid/ready handshake and registers operands and opcode onto the ALU inputs.
- Captures the ALU result and flags one cycle later, presents them downstream over a second valid/ready handshake, and keeps an accumulator and sticky flags.

---
 rtl/alu_acc_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_alu_acc_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_acc_ctrl.sv
// -----------------------------------------------------------------------------
// alu_acc_ctrl
//   Sequential control stage around an external N-bit combinational ALU.
//   A command (opcode, operands, operand-A source) is accepted over a
//   valid/ready handshake and registered onto the ALU inputs. One cycle later
//   the ALU result and flags are captured, held for downstream over a second
//   valid/ready handshake, and folded into an accumulator, sticky carry/borrow
//   flags and a saturating completed-operation counter.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          command handshake
//   in_op, in_a, in_b, in_src  opcode, operands, A source (1: use acc)
//   alu_a, alu_b, alu_sel      registered ALU inputs
//   alu_y, alu_zero,
//   alu_cout, alu_borrow       combinational ALU result and flags
//   out_valid/out_ready        result handshake
//   out_y, out_zero, out_cout,
//   out_borrow, out_err        registered result, flags, illegal-opcode flag
//   acc                        accumulator
//   sticky_cout, sticky_borrow OR of captured carries/borrows since last clear
//   clr_sticky, acc_clr        synchronous clears
//   op_cnt                     saturating count of handed-off results
// -----------------------------------------------------------------------------
module alu_acc_ctrl #(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_src,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [3:0]       alu_sel,
    input  logic [N-1:0]     alu_y,
    input  logic             alu_zero,
    input  logic             alu_cout,
    input  logic             alu_borrow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_y,
    output logic             out_zero,
    output logic             out_cout,
    output logic             out_borrow,
    output logic             out_err,
    output logic [N-1:0]     acc,
    output logic             sticky_cout,
    output logic             sticky_borrow,
    input  logic             clr_sticky,
    input  logic             acc_clr,
    output logic [CNT_W-1:0] op_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Highest legal opcode (xor); anything above is flagged as an error.
    localparam logic [3:0] OP_MAX = 4'b0100;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [N-1:0]     r_alu_a;
    logic [N-1:0]     r_alu_b;
    logic [3:0]       r_alu_sel;
    logic [N-1:0]     r_out_y;
    logic             r_out_zero;
    logic             r_out_cout;
    logic             r_out_borrow;
    logic             r_out_err;
    logic [N-1:0]     r_acc;
    logic             r_sticky_cout;
    logic             r_sticky_borrow;
    logic [CNT_W-1:0] r_op_cnt;

    logic             w_accept;
    logic             w_exec;
    logic             w_handoff;
    logic             w_illegal;

    // in_ready is gated by rst_n so it reads 0 while reset is held and
    // comes back as soon as reset is released with the FSM in IDLE.
    assign in_ready  = rst_n && (r_state == S_IDLE);
    assign w_accept  = in_valid && in_ready;
    assign w_exec    = (r_state == S_EXEC);
    assign w_handoff = (r_state == S_DONE) && out_ready;
    assign w_illegal = (r_alu_sel > OP_MAX);

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // ALU operand registers: loaded only on accept, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
        end else if (w_accept) begin
            r_alu_a   <= in_src ? r_acc : in_a;
            r_alu_b   <= in_b;
            r_alu_sel <= in_op;
        end
    end

    // Result capture at the end of the single EXEC cycle; stable through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_y      <= '0;
            r_out_zero   <= 1'b0;
            r_out_cout   <= 1'b0;
            r_out_borrow <= 1'b0;
            r_out_err    <= 1'b0;
        end else if (w_exec) begin
            r_out_y      <= alu_y;
            r_out_zero   <= alu_zero;
            r_out_cout   <= alu_cout;
            r_out_borrow <= alu_borrow;
            r_out_err    <= w_illegal;
        end
    end

    // A legal capture takes priority over a coincident acc_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_acc <= '0;
        else if (w_exec && !w_illegal) r_acc <= alu_y;
        else if (acc_clr)              r_acc <= '0;
    end

    // Clear-then-OR: a coincident clear still keeps the flags of this capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky_cout   <= 1'b0;
            r_sticky_borrow <= 1'b0;
        end else if (w_exec) begin
            r_sticky_cout   <= (r_sticky_cout   && !clr_sticky) || alu_cout;
            r_sticky_borrow <= (r_sticky_borrow && !clr_sticky) || alu_borrow;
        end else if (clr_sticky) begin
            r_sticky_cout   <= 1'b0;
            r_sticky_borrow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            r_op_cnt <= '0;
        else if (w_handoff && r_op_cnt != '1)  r_op_cnt <= r_op_cnt + CNT_W'(1);
    end

    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;
    assign alu_sel       = r_alu_sel;
    assign out_valid     = (r_state == S_DONE);
    assign out_y         = r_out_y;
    assign out_zero      = r_out_zero;
    assign out_cout      = r_out_cout;
    assign out_borrow    = r_out_borrow;
    assign out_err       = r_out_err;
    assign acc           = r_acc;
    assign sticky_cout   = r_sticky_cout;
    assign sticky_borrow = r_sticky_borrow;
    assign op_cnt        = r_op_cnt;

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_acc_ctrl
//   Self-checking bench for alu_acc_ctrl (N=8, CNT_W=8). The external ALU and
//   the expected behaviour are modelled at transaction level: one command in,
//   one result out, with accumulator / sticky / counter state kept as plain
//   variables.
// -----------------------------------------------------------------------------
module tb_alu_acc_ctrl;

    localparam int N     = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic             in_src;
    logic [N-1:0]     alu_a;
    logic [N-1:0]     alu_b;
    logic [3:0]       alu_sel;
    logic [N-1:0]     alu_y;
    logic             alu_zero;
    logic             alu_cout;
    logic             alu_borrow;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_y;
    logic             out_zero;
    logic             out_cout;
    logic             out_borrow;
    logic             out_err;
    logic [N-1:0]     acc;
    logic             sticky_cout;
    logic             sticky_borrow;
    logic             clr_sticky;
    logic             acc_clr;
    logic [CNT_W-1:0] op_cnt;

    alu_acc_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_src(in_src),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_y(alu_y), .alu_zero(alu_zero), .alu_cout(alu_cout), .alu_borrow(alu_borrow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_zero(out_zero), .out_cout(out_cout),
        .out_borrow(out_borrow), .out_err(out_err),
        .acc(acc), .sticky_cout(sticky_cout), .sticky_borrow(sticky_borrow),
        .clr_sticky(clr_sticky), .acc_clr(acc_clr), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural ALU ----------------
    typedef struct packed {
        logic [7:0] y;
        logic       z;
        logic       c;
        logic       bo;
    } alu_res_t;

    function automatic alu_res_t model_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        alu_res_t r;
        int       ia;
        int       ib;
        ia = int'(a);
        ib = int'(b);
        r  = '0;
        case (op)
            4'd0: begin r.y = 8'((ia + ib) % 256); r.c = (ia + ib) > 255; end
            4'd1: begin r.y = 8'((ia - ib + 256) % 256); r.bo = ia < ib; end
            4'd2: r.y = a & b;
            4'd3: r.y = a | b;
            4'd4: r.y = a ^ b;
            default: r.y = 8'd0;
        endcase
        r.z = (r.y == 8'd0);
        return r;
    endfunction

    always_comb begin
        alu_res_t r;
        r          = model_alu(alu_sel, alu_a, alu_b);
        alu_y      = r.y;
        alu_zero   = r.z;
        alu_cout   = r.c;
        alu_borrow = r.bo;
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference state at transaction level
    logic [7:0] m_acc;
    logic       m_sc;
    logic       m_sb;
    int         m_cnt;

    // Values observed in DONE for the last operation
    logic [7:0] o_y;
    logic       o_z;
    logic       o_c;
    logic       o_bo;
    logic       o_err;

    task automatic model_reset();
        m_acc = 8'd0;
        m_sc  = 1'b0;
        m_sb  = 1'b0;
        m_cnt = 0;
    endtask

    // One full command: accept, EXEC, optional backpressure, handoff.
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic src, input int stall,
                          input logic clr_exec, input logic accclr_exec);
        alu_res_t   e;
        logic [7:0] ea;
        logic       eerr;
        ea   = src ? m_acc : a;
        e    = model_alu(op, ea, b);
        eerr = (op > 4'd4);

        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_src = src;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);            // accept edge
        @(negedge clk);            // EXEC cycle
        in_valid = 1'b0;
        clr_sticky = clr_exec;
        acc_clr    = accclr_exec;
        check("in_ready_exec", 32'(in_ready), 32'd0);
        check("out_valid_exec", 32'(out_valid), 32'd0);
        check("alu_a", 32'(alu_a), 32'(ea));
        check("alu_b", 32'(alu_b), 32'(b));
        check("alu_sel", 32'(alu_sel), 32'(op));
        @(posedge clk);            // capture edge
        @(negedge clk);            // DONE
        clr_sticky = 1'b0;
        acc_clr    = 1'b0;

        if (!eerr)           m_acc = e.y;
        else if (accclr_exec) m_acc = 8'd0;
        m_sc = (m_sc && !clr_exec) || e.c;
        m_sb = (m_sb && !clr_exec) || e.bo;

        check("out_valid_latency", 32'(out_valid), 32'd1);
        o_y = out_y; o_z = out_zero; o_c = out_cout; o_bo = out_borrow; o_err = out_err;
        check("out_y", 32'(out_y), 32'(e.y));
        check("out_zero", 32'(out_zero), 32'(e.z));
        check("out_cout", 32'(out_cout), 32'(e.c));
        check("out_borrow", 32'(out_borrow), 32'(e.bo));
        check("out_err", 32'(out_err), 32'(eerr));
        check("acc", 32'(acc), 32'(m_acc));
        check("sticky_cout", 32'(sticky_cout), 32'(m_sc));
        check("sticky_borrow", 32'(sticky_borrow), 32'(m_sb));
        check("alu_a_hold", 32'(alu_a), 32'(ea));

        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_y", 32'(out_y), 32'(o_y));
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_op_cnt", 32'(op_cnt), 32'(m_cnt));
        end
        out_ready = 1'b1;
        @(posedge clk);            // handoff edge
        @(negedge clk);
        out_ready = 1'b0;
        if (m_cnt < 255) m_cnt++;
        check("out_valid_after", 32'(out_valid), 32'd0);
        check("op_cnt", 32'(op_cnt), 32'(m_cnt));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       src;
        logic       pre_clr;
        logic       clr_exec;
        int         stall;
        logic [7:0] y;
        logic       z;
        logic       c;
        logic       bo;
        logic       err;
        logic [7:0] acc;
        logic       sc;
        logic       sb;
        int         cnt;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{4'd0, 8'd200, 8'd100, 1'b0, 1'b0, 1'b0, 0, 8'd44,  1'b0, 1'b1, 1'b0, 1'b0, 8'd44,  1'b1, 1'b0, 1};
        vecs[1]  = '{4'd0, 8'd99,  8'd3,   1'b1, 1'b1, 1'b0, 0, 8'd3,   1'b0, 1'b0, 1'b0, 1'b0, 8'd3,   1'b1, 1'b0, 2};
        vecs[2]  = '{4'd0, 8'd99,  8'd3,   1'b1, 1'b0, 1'b0, 0, 8'd6,   1'b0, 1'b0, 1'b0, 1'b0, 8'd6,   1'b1, 1'b0, 3};
        vecs[3]  = '{4'd0, 8'd99,  8'd3,   1'b1, 1'b0, 1'b0, 5, 8'd9,   1'b0, 1'b0, 1'b0, 1'b0, 8'd9,   1'b1, 1'b0, 4};
        vecs[4]  = '{4'hA, 8'd1,   8'd2,   1'b0, 1'b0, 1'b0, 0, 8'd0,   1'b1, 1'b0, 1'b0, 1'b1, 8'd9,   1'b1, 1'b0, 5};
        vecs[5]  = '{4'd1, 8'd5,   8'd7,   1'b0, 1'b0, 1'b0, 0, 8'd254, 1'b0, 1'b0, 1'b1, 1'b0, 8'd254, 1'b1, 1'b1, 6};
        vecs[6]  = '{4'd1, 8'd7,   8'd7,   1'b0, 1'b0, 1'b0, 0, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 1'b1, 7};
        vecs[7]  = '{4'd0, 8'd255, 8'd1,   1'b0, 1'b0, 1'b1, 0, 8'd0,   1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 8};
        vecs[8]  = '{4'd2, 8'hF0,  8'h3C,  1'b0, 1'b0, 1'b0, 0, 8'h30,  1'b0, 1'b0, 1'b0, 1'b0, 8'h30,  1'b1, 1'b0, 9};
        vecs[9]  = '{4'd3, 8'hF0,  8'h0F,  1'b0, 1'b0, 1'b0, 0, 8'hFF,  1'b0, 1'b0, 1'b0, 1'b0, 8'hFF,  1'b1, 1'b0, 10};
        vecs[10] = '{4'd4, 8'hAA,  8'hFF,  1'b0, 1'b0, 1'b0, 0, 8'h55,  1'b0, 1'b0, 1'b0, 1'b0, 8'h55,  1'b1, 1'b0, 11};
        vecs[11] = '{4'd0, 8'h80,  8'h80,  1'b0, 1'b0, 1'b0, 2, 8'h00,  1'b1, 1'b1, 1'b0, 1'b0, 8'h00,  1'b1, 1'b0, 12};

        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_src = 1'b0;
        out_ready = 1'b0; clr_sticky = 1'b0; acc_clr = 1'b0;
        model_reset();

        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_sel", 32'(alu_sel), 32'd0);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_op_cnt", 32'(op_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].pre_clr) begin
                @(negedge clk); acc_clr = 1'b1;
                @(posedge clk);
                @(negedge clk); acc_clr = 1'b0;
                m_acc = 8'd0;
                check("acc_clr_idle", 32'(acc), 32'd0);
            end
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].src, vecs[i].stall, vecs[i].clr_exec, 1'b0);
            check($sformatf("v%0d_y", i), 32'(o_y), 32'(vecs[i].y));
            check($sformatf("v%0d_zero", i), 32'(o_z), 32'(vecs[i].z));
            check($sformatf("v%0d_cout", i), 32'(o_c), 32'(vecs[i].c));
            check($sformatf("v%0d_borrow", i), 32'(o_bo), 32'(vecs[i].bo));
            check($sformatf("v%0d_err", i), 32'(o_err), 32'(vecs[i].err));
            check($sformatf("v%0d_acc", i), 32'(acc), 32'(vecs[i].acc));
            check($sformatf("v%0d_sc", i), 32'(sticky_cout), 32'(vecs[i].sc));
            check($sformatf("v%0d_sb", i), 32'(sticky_borrow), 32'(vecs[i].sb));
            check($sformatf("v%0d_cnt", i), 32'(op_cnt), 32'(vecs[i].cnt));
        end

        // acc_clr coincident with a legal capture: the capture wins
        run_op(4'd0, 8'd10, 8'd5, 1'b0, 0, 1'b0, 1'b1);
        check("accclr_vs_capture", 32'(acc), 32'd15);

        // acc_clr and clr_sticky while idle
        @(negedge clk); acc_clr = 1'b1; clr_sticky = 1'b1;
        @(posedge clk);
        @(negedge clk); acc_clr = 1'b0; clr_sticky = 1'b0;
        m_acc = 8'd0; m_sc = 1'b0; m_sb = 1'b0;
        check("idle_acc_clr", 32'(acc), 32'd0);
        check("idle_clr_sc", 32'(sticky_cout), 32'd0);
        check("idle_clr_sb", 32'(sticky_borrow), 32'd0);

        // Reset asserted asynchronously in the middle of EXEC
        run_op(4'd0, 8'd250, 8'd10, 1'b0, 0, 1'b0, 1'b0);   // leaves sc=1, acc=4
        @(negedge clk);
        in_valid = 1'b1; in_op = 4'd0; in_a = 8'd200; in_b = 8'd100; in_src = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        in_valid = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_acc", 32'(acc), 32'd0);
        check("mid_rst_sc", 32'(sticky_cout), 32'd0);
        check("mid_rst_cnt", 32'(op_cnt), 32'd0);
        check("mid_rst_alu_a", 32'(alu_a), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_out_valid", 32'(out_valid), 32'd0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("rel_no_pulse", 32'(out_valid), 32'd0);
        end

        // Randomised stream against the reference model; long enough to
        // saturate op_cnt.
        for (int i = 0; i < 270; i++) begin
            logic [3:0] rop;
            rop = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
            run_op(rop, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)), ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
        end
        check("op_cnt_saturated", 32'(op_cnt), 32'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
